// File: rtl/posix_time_pkg.sv
// Shared types and constants for the POSIX time path (counter and time-of-day conversion).
package posix_time_pkg;

    typedef logic [31:0] posix_time_t;

    localparam int unsigned SEC_IN_MIN  = 60;
    localparam int unsigned MIN_IN_HOUR = 60;
    localparam int unsigned HOUR_IN_DAY = 24;
    localparam int unsigned SEC_IN_HOUR = SEC_IN_MIN * MIN_IN_HOUR;

    // Counter control states
    typedef enum logic [1:0] {
        UNSET  = 2'd0,
        COMMIT = 2'd1,
        RUN    = 2'd2
    } state_e;

endpackage

// File: rtl/second_tick_gen.sv
// Prescaler producing a one-cycle pulse on the last clock of each second.
// With POSIX_TIME_COUNTER_TRIM_EN defined, the length of each second is trimmed by a signed
// clock count latched at the start of that second.
module second_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        enable_i,
`ifdef POSIX_TIME_COUNTER_TRIM_EN
    input  logic [15:0] trim_i,
`endif
    output logic        boundary_o
);

`ifdef POSIX_TIME_COUNTER_TRIM_EN
    // Trimmed seconds can be up to 2*CLK_FREQ_HZ clocks long
    localparam int unsigned PrescW = $clog2(2 * CLK_FREQ_HZ);
`else
    localparam int unsigned PrescW = $clog2(CLK_FREQ_HZ);
`endif

    logic [PrescW-1:0] presc_q, presc_d;
    logic [PrescW-1:0] term_count;

`ifdef POSIX_TIME_COUNTER_TRIM_EN
    localparam logic signed [33:0] FreqS  = 34'(CLK_FREQ_HZ);
    localparam logic signed [33:0] MaxTcS = 34'(2 * CLK_FREQ_HZ - 1);

    logic signed [15:0] trim_q, trim_d;
    logic signed [33:0] tc_raw;

    // Terminal count for the current second, clamped to a sane range
    always_comb begin
        tc_raw = FreqS - 34'sd1 + 34'(trim_q);
        if (tc_raw < 34'sd1) begin
            term_count = PrescW'(1);
        end else if (tc_raw > MaxTcS) begin
            term_count = PrescW'(2 * CLK_FREQ_HZ - 1);
        end else begin
            term_count = tc_raw[PrescW-1:0];
        end
    end

    // Latch a new trim at the start of every second (boundary or restart)
    always_comb begin
        trim_d = trim_q;
        if (clear_i || boundary_o) begin
            trim_d = trim_i;
        end
    end

    // Trim register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trim_q <= '0;
        end else begin
            trim_q <= trim_d;
        end
    end
`else
    assign term_count = PrescW'(CLK_FREQ_HZ - 1);
`endif

    assign boundary_o = enable_i && !clear_i && (presc_q == term_count);

    // Prescaler next state: clear wins, otherwise count and wrap at terminal
    always_comb begin
        presc_d = presc_q;
        if (clear_i) begin
            presc_d = '0;
        end else if (enable_i) begin
            if (presc_q == term_count) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PrescW'(1);
            end
        end
    end

    // Prescaler register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/posix_time_counter.sv
// Free-running 32-bit POSIX seconds counter, loadable over a valid/ready handshake.
// A load is captured, committed one cycle later, and restarts the second at that point.
// Optional: POSIX_TIME_COUNTER_TRIM_EN adds trim_i for per-second clock-count correction.
module posix_time_counter
    import posix_time_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter bit          RUN_FROM_RESET = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_valid_i,
    input  logic [31:0] load_time_i,
    output logic        load_ready_o,
    output logic [31:0] posix_time_o,
    output logic        tick_o,
`ifdef POSIX_TIME_COUNTER_TRIM_EN
    input  logic [15:0] trim_i,
`endif
    output logic        time_valid_o
);

    state_e      state_q, state_d;
    posix_time_t time_q, time_d;
    posix_time_t load_q, load_d;
    logic        tick_q, tick_d;
    logic        valid_q, valid_d;

    logic accept;
    logic boundary;
    logic presc_clear;
    logic presc_en;

    second_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_second_tick_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (presc_clear),
        .enable_i  (presc_en),
`ifdef POSIX_TIME_COUNTER_TRIM_EN
        .trim_i    (trim_i),
`endif
        .boundary_o(boundary)
    );

    assign load_ready_o = (state_q != COMMIT) && !rst_i;
    assign accept       = load_valid_i && load_ready_o;

    // Next state: a load always beats a coincident second boundary
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        load_d      = load_q;
        tick_d      = 1'b0;
        valid_d     = valid_q;
        presc_clear = 1'b0;
        presc_en    = 1'b0;

        case (state_q)
            UNSET: presc_en = RUN_FROM_RESET;
            RUN:   presc_en = 1'b1;
            COMMIT: begin
                time_d      = load_q;
                valid_d     = 1'b1;
                presc_clear = 1'b1;
                state_d     = RUN;
            end
            default: state_d = UNSET;
        endcase

        if (state_q == UNSET || state_q == RUN) begin
            if (accept) begin
                load_d  = load_time_i;
                state_d = COMMIT;
            end else if (boundary) begin
                time_d = time_q + 32'd1;
                tick_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= UNSET;
            time_q  <= '0;
            load_q  <= '0;
            tick_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            load_q  <= load_d;
            tick_q  <= tick_d;
            valid_q <= valid_d;
        end
    end

    assign posix_time_o = time_q;
    assign tick_o       = tick_q;
    assign time_valid_o = valid_q;

endmodule
